// File: rtl/vnp4_tx_framer.sv
// vnp4_tx_framer: store-and-forward AXI-Stream to VNP4 user-metadata framer.
// Each packet is fully buffered, so user_size is already known on its first output beat.
// Ports:
//   axis_aclk, axis_aresetn         clock, asynchronous active-low reset
//   s_axis_*                        512-bit input stream (tvalid/tready/tdata/tkeep/tlast)
//   s_src_pf/s_src_cmac/s_dst_pf/s_dst_cmac/s_from_direction/s_to_direction
//                                   routing sideband, taken from the first beat of each packet
//   m_axis_*                        VNP4 master stream: valid/data/keep/last, user_* metadata, ready in
//   drop_count                      dropped-packet counter (only with VNP4_TX_FRAMER_DROP_EN)
// Macro VNP4_TX_FRAMER_DROP_EN: drop oversize packets instead of stalling, and count them.
module vnp4_tx_framer #(
    parameter int DATA_DEPTH    = 256,
    parameter int META_DEPTH    = 16,
    parameter int MAX_PKT_BYTES = 9216
) (
    input  logic         axis_aclk,
    input  logic         axis_aresetn,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic [511:0] s_axis_tdata,
    input  logic [63:0]  s_axis_tkeep,
    input  logic         s_axis_tlast,
    input  logic [3:0]   s_src_pf,
    input  logic [9:0]   s_src_cmac,
    input  logic [3:0]   s_dst_pf,
    input  logic [9:0]   s_dst_cmac,
    input  logic         s_from_direction,
    input  logic         s_to_direction,
`ifdef VNP4_TX_FRAMER_DROP_EN
    output logic [31:0]  drop_count,
`endif
    output logic         m_axis_valid,
    output logic [511:0] m_axis_data,
    output logic [63:0]  m_axis_keep,
    output logic         m_axis_last,
    output logic         m_axis_user_valid,
    output logic [15:0]  m_axis_user_size,
    output logic [3:0]   m_axis_user_src_pf,
    output logic [9:0]   m_axis_user_src_cmac,
    output logic [3:0]   m_axis_user_dst_pf,
    output logic [9:0]   m_axis_user_dst_cmac,
    output logic         m_axis_user_from_direction,
    output logic         m_axis_user_to_direction,
    input  logic         m_axis_ready
);
    localparam int AW = $clog2(DATA_DEPTH);
    localparam int MW = $clog2(META_DEPTH);
    localparam int BW = 512 + 64 + 1;
    localparam int DW = 16 + 30;
    localparam logic [AW:0] A1 = 1;
    localparam logic [MW:0] M1 = 1;
    localparam logic [AW:0] D_FULL = (AW + 1)'(DATA_DEPTH);
    localparam logic [MW:0] M_FULL = (MW + 1)'(META_DEPTH);

    if (DATA_DEPTH * 64 < MAX_PKT_BYTES) begin : g_size_chk
        $error("DATA_DEPTH cannot hold a MAX_PKT_BYTES packet");
    end

    typedef enum logic [1:0] {IN_FIRST, IN_BODY, IN_DROP} in_state_t;
    typedef enum logic {EG_IDLE, EG_SEND} eg_state_t;

    logic [BW-1:0] data_mem [DATA_DEPTH];
    logic [DW-1:0] meta_mem [META_DEPTH];
    in_state_t in_q, in_d;
    eg_state_t eg_q, eg_d;
    logic [AW:0] wr_spec_q, wr_spec_d, wr_com_q, wr_com_d, rd_q, rd_d;
    logic [MW:0] mwr_q, mwr_d, mrd_q, mrd_d, mrd_nx, meta_cnt;
    logic [15:0] acc_q, acc_d, acc_base, size;
    logic [29:0] side_q, side_d, side_in;
    logic [6:0] pop;
    logic rdy_en_q, data_full, meta_full, accept, wr_en, meta_push;
    logic [BW-1:0] beat_q, beat_d, head_beat;
    logic [DW-1:0] desc_q, desc_d;

    assign pop = 7'($countones(s_axis_tkeep));
    assign side_in = {s_src_pf, s_src_cmac, s_dst_pf, s_dst_cmac, s_from_direction, s_to_direction};
    assign acc_base = in_q == IN_FIRST ? 16'd0 : acc_q;
    assign meta_cnt = mwr_q - mrd_q;
    assign mrd_nx = mrd_q + M1;
    // Fullness uses the speculative pointer so an uncommitted packet cannot overrun the reader.
    assign data_full = (wr_spec_q - rd_q) == D_FULL;
    assign meta_full = meta_cnt == M_FULL;
    // rdy_en_q keeps tready low through reset and releases it one edge after.
    assign s_axis_tready = rdy_en_q && (in_q == IN_DROP || (!data_full && !meta_full));
    assign accept = s_axis_tvalid && s_axis_tready;
    assign wr_en = accept && in_q != IN_DROP;
    assign head_beat = data_mem[rd_q[AW-1:0]];

`ifdef VNP4_TX_FRAMER_DROP_EN
    logic [31:0] drop_q, drop_d, drop_inc;
    logic [16:0] sum;
    logic too_big;
    assign sum = {1'b0, acc_base} + {10'd0, pop};
    assign size = sum[16] ? 16'hFFFF : sum[15:0];
    assign too_big = sum > 17'(MAX_PKT_BYTES) || (!s_axis_tlast && (wr_spec_q + A1 - wr_com_q) == D_FULL);
    assign drop_inc = drop_q + {31'd0, ~&drop_q};
    assign drop_count = drop_q;
`else
    assign size = acc_base + {9'd0, pop};
`endif

    always_comb begin
        in_d = in_q;
        wr_spec_d = wr_spec_q;
        wr_com_d = wr_com_q;
        mwr_d = mwr_q;
        acc_d = acc_q;
        side_d = side_q;
        meta_push = 1'b0;
`ifdef VNP4_TX_FRAMER_DROP_EN
        drop_d = drop_q;
`endif
        if (wr_en) begin
            wr_spec_d = wr_spec_q + A1;
            acc_d = size;
            side_d = in_q == IN_FIRST ? side_in : side_q;
            in_d = s_axis_tlast ? IN_FIRST : IN_BODY;
            if (s_axis_tlast) begin
                meta_push = 1'b1;
                mwr_d = mwr_q + M1;
                wr_com_d = wr_spec_q + A1;
            end
`ifdef VNP4_TX_FRAMER_DROP_EN
            // Rewinding to the committed pointer discards every beat of this packet.
            if (too_big) begin
                wr_spec_d = wr_com_q;
                wr_com_d = wr_com_q;
                mwr_d = mwr_q;
                meta_push = 1'b0;
                in_d = s_axis_tlast ? IN_FIRST : IN_DROP;
                if (s_axis_tlast) drop_d = drop_inc;
            end
        end else if (accept && s_axis_tlast) begin
            in_d = IN_FIRST;
            drop_d = drop_inc;
        end
`else
        end
`endif
    end

    always_ff @(posedge axis_aclk) begin
        if (wr_en) data_mem[wr_spec_q[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        if (meta_push) meta_mem[mwr_q[MW-1:0]] <= {size, side_d};
    end

    // The descriptor stays in the meta FIFO until its last beat transfers; the next one
    // (at mrd_q+1) is preloaded on that same edge for back-to-back output.
    always_comb begin
        eg_d = eg_q;
        rd_d = rd_q;
        mrd_d = mrd_q;
        beat_d = beat_q;
        desc_d = desc_q;
        if (eg_q == EG_IDLE) begin
            if (meta_cnt != '0) begin
                eg_d = EG_SEND;
                beat_d = head_beat;
                desc_d = meta_mem[mrd_q[MW-1:0]];
                rd_d = rd_q + A1;
            end
        end else if (m_axis_ready) begin
            if (!beat_q[0]) begin
                beat_d = head_beat;
                rd_d = rd_q + A1;
            end else begin
                mrd_d = mrd_nx;
                if (meta_cnt > M1) begin
                    beat_d = head_beat;
                    desc_d = meta_mem[mrd_nx[MW-1:0]];
                    rd_d = rd_q + A1;
                end else begin
                    eg_d = EG_IDLE;
                end
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            in_q <= IN_FIRST;
            eg_q <= EG_IDLE;
            wr_spec_q <= '0;
            wr_com_q <= '0;
            rd_q <= '0;
            mwr_q <= '0;
            mrd_q <= '0;
            acc_q <= '0;
            side_q <= '0;
            rdy_en_q <= 1'b0;
            beat_q <= '0;
            desc_q <= '0;
`ifdef VNP4_TX_FRAMER_DROP_EN
            drop_q <= '0;
`endif
        end else begin
            in_q <= in_d;
            eg_q <= eg_d;
            wr_spec_q <= wr_spec_d;
            wr_com_q <= wr_com_d;
            rd_q <= rd_d;
            mwr_q <= mwr_d;
            mrd_q <= mrd_d;
            acc_q <= acc_d;
            side_q <= side_d;
            rdy_en_q <= 1'b1;
            beat_q <= beat_d;
            desc_q <= desc_d;
`ifdef VNP4_TX_FRAMER_DROP_EN
            drop_q <= drop_d;
`endif
        end
    end

    assign m_axis_valid = eg_q == EG_SEND;
    assign m_axis_user_valid = m_axis_valid;
    assign {m_axis_data, m_axis_keep, m_axis_last} = beat_q;
    assign {m_axis_user_size, m_axis_user_src_pf, m_axis_user_src_cmac, m_axis_user_dst_pf,
            m_axis_user_dst_cmac, m_axis_user_from_direction, m_axis_user_to_direction} = desc_q;
endmodule

// File: tb/tb_vnp4_tx_framer.sv
// tb_vnp4_tx_framer: randomized packet traffic against a packet-level reference model.
module tb_vnp4_tx_framer;
    localparam int MAX_PKT_BYTES = 9216;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [511:0] s_data = '0;
    logic [63:0]  s_keep = '0;
    logic [3:0]   s_src_pf = '0, s_dst_pf = '0;
    logic [9:0]   s_src_cmac = '0, s_dst_cmac = '0;
    logic         s_from = 1'b0, s_to = 1'b0;
    logic         m_valid, m_last, m_user_valid, m_from, m_to;
    logic         m_ready = 1'b0;
    logic [511:0] m_data;
    logic [63:0]  m_keep;
    logic [15:0]  m_size;
    logic [3:0]   m_src_pf, m_dst_pf;
    logic [9:0]   m_src_cmac, m_dst_cmac;
`ifdef VNP4_TX_FRAMER_DROP_EN
    logic [31:0]  drop_count;
`endif

    vnp4_tx_framer dut (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
        .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
        .s_src_pf(s_src_pf), .s_src_cmac(s_src_cmac), .s_dst_pf(s_dst_pf), .s_dst_cmac(s_dst_cmac),
        .s_from_direction(s_from), .s_to_direction(s_to),
`ifdef VNP4_TX_FRAMER_DROP_EN
        .drop_count(drop_count),
`endif
        .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_keep(m_keep), .m_axis_last(m_last),
        .m_axis_user_valid(m_user_valid), .m_axis_user_size(m_size),
        .m_axis_user_src_pf(m_src_pf), .m_axis_user_src_cmac(m_src_cmac),
        .m_axis_user_dst_pf(m_dst_pf), .m_axis_user_dst_cmac(m_dst_cmac),
        .m_axis_user_from_direction(m_from), .m_axis_user_to_direction(m_to),
        .m_axis_ready(m_ready)
    );

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic [15:0]  sz;
        logic [29:0]  sd;
    } beat_t;

    beat_t exp_q[$];
    beat_t pend[$];
    int checks = 0, errors = 0, drop_exp = 0, ready_mode = 0;
    logic hold = 1'b0;
    logic [511:0] held_d;
    logic [110:0] held_ctl;
    logic [29:0] s_side, m_side;

    assign s_side = {s_src_pf, s_src_cmac, s_dst_pf, s_dst_cmac, s_from, s_to};
    assign m_side = {m_src_pf, m_src_cmac, m_dst_pf, m_dst_cmac, m_from, m_to};

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(1));
            2: m_ready = ~m_ready;
            default: m_ready = 1'b0;
        endcase
    end

    // Input side of the model: a packet is the beats up to tlast; its size is the total
    // number of kept bytes and its sideband is whatever was on the first beat.
    always @(negedge clk) begin
        beat_t b;
        int total;
        if (!rst_n) begin
            pend.delete();
            exp_q.delete();
            drop_exp = 0;
        end else if (s_valid && s_ready) begin
            b.d = s_data;
            b.k = s_keep;
            b.l = s_last;
            b.sz = '0;
            b.sd = pend.size() == 0 ? s_side : pend[0].sd;
            pend.push_back(b);
            if (s_last) begin
                total = 0;
                foreach (pend[i]) for (int j = 0; j < 64; j++) total += int'(pend[i].k[j]);
`ifdef VNP4_TX_FRAMER_DROP_EN
                if (total > MAX_PKT_BYTES) begin
                    drop_exp++;
                    pend.delete();
                end
`endif
                foreach (pend[i]) begin
                    pend[i].sz = 16'(total);
                    exp_q.push_back(pend[i]);
                end
                pend.delete();
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (hold) begin
                check("hold_data", m_data, held_d);
                check("hold_ctl", {m_keep, m_last, m_size, m_side}, held_ctl);
            end
            if (m_valid) check("user_valid", m_user_valid, 1'b1);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", m_data, e.d);
                    check("keep", m_keep, e.k);
                    check("last", m_last, e.l);
                    check("user_size", m_size, e.sz);
                    check("sideband", m_side, e.sd);
                end
            end
            hold = m_valid && !m_ready;
            held_d = m_data;
            held_ctl = {m_keep, m_last, m_size, m_side};
        end else begin
            hold = 1'b0;
        end
    end

    task automatic drive_beat(input logic [63:0] k, input logic l, input logic [29:0] sd);
        for (int i = 0; i < 16; i++) s_data[i*32 +: 32] = $urandom();
        s_keep = k;
        s_last = l;
        {s_src_pf, s_src_cmac, s_dst_pf, s_dst_cmac, s_from, s_to} = sd;
        s_valid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (s_ready) break;
            if (n == 3000) begin
                check("in_stall", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    function automatic logic [63:0] rand_keep();
        case ($urandom_range(3))
            0: return '1;
            1: return '0;
            2: return {$urandom(), $urandom()};
            default: return {64{1'b1}} >> $urandom_range(63);
        endcase
    endfunction

    task automatic send_pkt(input int nb, input bit gaps);
        for (int b = 0; b < nb; b++) begin
            if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
            drive_beat(rand_keep(), b == nb - 1, 30'($urandom()));
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 5000 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tready", s_ready, 1'b0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_user_valid", m_user_valid, 1'b0);
        check("rst_data", m_data, '0);
        check("rst_user", {m_size, m_side}, '0);
`ifdef VNP4_TX_FRAMER_DROP_EN
        check("rst_drop_count", drop_count, '0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("tready_after_rst", s_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single 16-byte beat: valid one edge after the accepting edge.
        drive_beat(64'h0000_0000_0000_FFFF, 1'b1, {4'd2, 10'd0, 4'd0, 10'h3, 2'b00});
        @(negedge clk);
        check("lat_early", m_valid, 1'b0);
        @(negedge clk);
        check("lat_valid", m_valid, 1'b1);
        check("one_size", m_size, 16'd16);
        check("one_src_pf", m_src_pf, 4'd2);
        check("one_dst_cmac", m_dst_cmac, 10'h3);
        check("one_last", m_last, 1'b1);
        @(negedge clk);
        check("one_done", m_valid, 1'b0);
        @(posedge clk);
        #1;

        // 130 bytes over 3 beats, emitted without a gap.
        drive_beat('1, 1'b0, 30'($urandom()));
        drive_beat('1, 1'b0, 30'($urandom()));
        drive_beat(64'h3, 1'b1, 30'($urandom()));
        for (int n = 0; n < 20 && !m_valid; n++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("gapless_valid", m_valid, 1'b1);
            check("gapless_last", m_last, i == 2);
            check("size_130", m_size, 16'd130);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        wait_drain();

        ready_mode = 2;
        repeat (4) send_pkt($urandom_range(1, 4), 1'b0);
        wait_drain();

        // Hold the output until the descriptor FIFO fills.
        ready_mode = 3;
        @(posedge clk);
        #1;
        repeat (16) send_pkt($urandom_range(1, 3), 1'b0);
        s_keep = '1;
        s_last = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        check("meta_full_tready", s_ready, 1'b0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        ready_mode = 0;
        wait_drain();

        ready_mode = 1;
        repeat (40) send_pkt($urandom_range(1, 6), 1'b1);
        ready_mode = 0;
        wait_drain();

        // Reset after 2 of 4 beats: nothing from the partial packet may appear.
        drive_beat(rand_keep(), 1'b0, 30'($urandom()));
        drive_beat(rand_keep(), 1'b0, 30'($urandom()));
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tready", s_ready, 1'b0);
        check("midrst_valid", m_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tready_up", s_ready, 1'b1);
        repeat (15) begin
            @(negedge clk);
            check("no_ghost", m_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        send_pkt(4, 1'b0);
        wait_drain();

`ifdef VNP4_TX_FRAMER_DROP_EN
        for (int b = 0; b < 145; b++) drive_beat('1, b == 144, 30'($urandom()));
        drive_beat('1, 1'b1, 30'($urandom()));
        wait_drain();
        check("drop_count", drop_count, drop_exp);
`endif

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
